note_sequencer: RTL and testbench

Pattern player that drives the tracker's note/speed inputs. Fetches 16-bit packed note rows from a synchronous pattern memory and holds each row for a programmable number of ticks. Converts tone/octave into a phase-increment speed and applies the per-tick sequencer effects (slide, drop, fade in, fade out) before presenting note and speed to the tracker. It is the producer end of the note interface that the tracker consumes.

---
 rtl/note_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_note_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Pattern player: fetches packed note rows from a synchronous pattern memory,
// converts tone/octave to a tracker speed and applies per-tick row effects.
module note_sequencer #(
  parameter int ROWS     = 64,
  parameter int ROWLEN   = $clog2(ROWS),
  parameter int TICKDIV  = 1024,
  parameter int MAXSPEED = 16,
  parameter int SPLEN    = $clog2(MAXSPEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [3:0]        ticks_per_row,
  input  logic [ROWLEN-1:0] pat_len,
  output logic              mem_rd,
  output logic [ROWLEN-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       note,
  output logic [SPLEN-1:0]  speed,
  output logic              row_strobe,
  output logic              playing,
  output logic              done
);

  localparam int PSW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [SPLEN-1:0] SPD_MAX = SPLEN'(MAXSPEED - 1);
  localparam logic [SPLEN-1:0] SPD_MIN = SPLEN'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_PLAY  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ROWLEN-1:0]  row_q, row_d;
  logic [PSW-1:0]     presc_q, presc_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [15:0]        note_q, note_d;
  logic [4:0]         row_vol_q, row_vol_d;
  logic [SPLEN-1:0]   speed_q, speed_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ROWLEN-1:0]  mem_addr_q, mem_addr_d;
  logic               row_strobe_q, row_strobe_d;
  logic               playing_q, playing_d;
  logic               done_q, done_d;

  logic               tick_s;
  logic               row_end_s;
  logic               last_row_s;
  logic [3:0]         tpr_eff_s;
  logic [6:0]         base_wide_s;
  logic [SPLEN-1:0]   base_speed_s;

  assign tick_s     = (state_q == S_PLAY) && (presc_q == PSW'(TICKDIV - 1));
  assign tpr_eff_s  = (ticks_per_row == 4'd0) ? 4'd1 : ticks_per_row;
  assign row_end_s  = tick_s && (tick_cnt_q == (tpr_eff_s - 4'd1));
  assign last_row_s = (row_q == pat_len);

  // Speed doubles per step of octave[2:1]; clamp to the tracker's range.
  assign base_wide_s  = ({4'd0, mem_data[15:13]} + 7'd1) << mem_data[12:11];
  assign base_speed_s = (base_wide_s > 7'(MAXSPEED - 1)) ? SPD_MAX : base_wide_s[SPLEN-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (start && !stop) ? S_FETCH : S_IDLE;
      S_FETCH: state_d = stop ? S_IDLE : S_LOAD;
      S_LOAD:  state_d = stop ? S_IDLE : S_PLAY;
      S_PLAY: begin
        if (stop)                         state_d = S_IDLE;
        else if (row_end_s && last_row_s) state_d = loop ? S_FETCH : S_IDLE;
        else if (row_end_s)               state_d = S_FETCH;
        else                              state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: strobes and memory port registered from the upcoming state
  always_comb begin
    mem_rd_d     = (state_d == S_FETCH);
    mem_addr_d   = (state_d == S_FETCH) ? row_d : mem_addr_q;
    row_strobe_d = (state_q == S_LOAD) && (state_d == S_PLAY);
    playing_d    = (state_d != S_IDLE);
    done_d       = (state_q == S_PLAY) && !stop && row_end_s && last_row_s && !loop;
  end

  // Row, prescaler and effect datapath
  always_comb begin
    row_d      = row_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    note_d     = note_q;
    row_vol_d  = row_vol_q;
    speed_d    = speed_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) row_d = {ROWLEN{1'b0}};
        else                row_d = row_q;
      end
      S_LOAD: begin
        presc_d    = {PSW{1'b0}};
        tick_cnt_d = 4'd0;
        // An all-zero word is a rest: the previous row keeps playing its effect.
        if (mem_data != 16'h0000) begin
          note_d    = mem_data;
          row_vol_d = mem_data[7:3];
          speed_d   = base_speed_s;
          if (mem_data[2:0] == 3'd4) note_d[7:3] = 5'd0;
          else                       note_d[7:3] = mem_data[7:3];
        end else begin
          note_d = note_q;
        end
      end
      S_PLAY: begin
        presc_d = tick_s ? {PSW{1'b0}} : presc_q + PSW'(1);
        if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          case (note_q[2:0])
            3'd1: begin
              if (speed_q < SPD_MAX) speed_d = speed_q + SPLEN'(1);
              else                   speed_d = speed_q;
            end
            3'd3: begin
              if (speed_q > SPD_MIN) speed_d = speed_q - SPLEN'(1);
              else                   speed_d = speed_q;
            end
            3'd4: begin
              if (note_q[7:3] < row_vol_q) note_d[7:3] = note_q[7:3] + 5'd1;
              else                         note_d[7:3] = note_q[7:3];
            end
            3'd5: begin
              if (note_q[7:3] != 5'd0) note_d[7:3] = note_q[7:3] - 5'd1;
              else                     note_d[7:3] = note_q[7:3];
            end
            default: speed_d = speed_q;
          endcase
          if (row_end_s) begin
            if (!last_row_s) row_d = row_q + ROWLEN'(1);
            else if (loop)   row_d = {ROWLEN{1'b0}};
            else             row_d = row_q;
          end else begin
            row_d = row_q;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: row_d = row_q;
    endcase
    if (state_d == S_IDLE) note_d[7:3] = 5'd0;
    else                   row_vol_d   = row_vol_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= {ROWLEN{1'b0}};
      presc_q      <= {PSW{1'b0}};
      tick_cnt_q   <= 4'd0;
      note_q       <= 16'h0000;
      row_vol_q    <= 5'd0;
      speed_q      <= {SPLEN{1'b0}};
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= {ROWLEN{1'b0}};
      row_strobe_q <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      row_q        <= row_d;
      presc_q      <= presc_d;
      tick_cnt_q   <= tick_cnt_d;
      note_q       <= note_d;
      row_vol_q    <= row_vol_d;
      speed_q      <= speed_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      row_strobe_q <= row_strobe_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign note       = note_q;
  assign speed      = speed_q;
  assign row_strobe = row_strobe_q;
  assign playing    = playing_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICKDIV=4 and a behavioural
// synchronous pattern memory; expected values are hand-computed per step.
module tb_note_sequencer;

  localparam int ROWS   = 64;
  localparam int ROWLEN = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [3:0]        ticks_per_row = 4'd2;
  logic [ROWLEN-1:0] pat_len = 6'd0;
  logic              mem_rd;
  logic [ROWLEN-1:0] mem_addr;
  logic [15:0]       mem_data = 16'h0000;
  logic [15:0]       note;
  logic [3:0]        speed;
  logic              row_strobe;
  logic              playing;
  logic              done;

  logic [15:0] mem [0:ROWS-1];
  int checks = 0;
  int errors = 0;
  int done_hits;

  note_sequencer #(.ROWS(ROWS), .TICKDIV(4), .MAXSPEED(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .ticks_per_row(ticks_per_row), .pat_len(pat_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .note(note), .speed(speed), .row_strobe(row_strobe),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  function automatic logic [15:0] mk(input int tone, input int oct, input int vol, input int eff);
    logic [15:0] w;
    w = {tone[2:0], oct[2:0], 2'b00, vol[4:0], eff[2:0]};
    return w;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at cycle 1 (FETCH) of a fresh playback
  task automatic start_play();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++) mem[i] = 16'h0000;

    // Reset values
    step(2);
    chk("rst_note", note, 16'h0000);
    chk("rst_speed", speed, 4'd0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 6'd0);
    chk("rst_strobe", row_strobe, 1'b0);
    chk("rst_playing", playing, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    step(2);
    chk("idle_no_read", mem_rd, 1'b0);

    // Two-row pattern, no loop
    mem[0] = mk(2, 2, 31, 0);
    mem[1] = mk(7, 6, 16, 0);
    ticks_per_row = 4'd2; pat_len = 6'd1; loop = 1'b0;
    start_play();
    chk("t1_c1_mem_rd", mem_rd, 1'b1);
    chk("t1_c1_addr", mem_addr, 6'd0);
    chk("t1_c1_playing", playing, 1'b1);
    step(1);
    chk("t1_c2_mem_rd", mem_rd, 1'b0);
    chk("t1_c2_strobe", row_strobe, 1'b0);
    step(1);
    chk("t1_c3_strobe", row_strobe, 1'b1);
    chk("t1_c3_note", note, mk(2, 2, 31, 0));
    chk("t1_c3_speed", speed, 4'd6);
    step(1);
    chk("t1_c4_strobe", row_strobe, 1'b0);
    step(7);
    chk("t1_c11_mem_rd", mem_rd, 1'b1);
    chk("t1_c11_addr", mem_addr, 6'd1);
    step(2);
    chk("t1_c13_strobe", row_strobe, 1'b1);
    chk("t1_c13_speed", speed, 4'd15);
    chk("t1_c13_note", note, mk(7, 6, 16, 0));
    step(7);
    chk("t1_c20_done", done, 1'b0);
    step(1);
    chk("t1_c21_done", done, 1'b1);
    chk("t1_c21_playing", playing, 1'b0);
    chk("t1_c21_note", note, mk(7, 6, 0, 0));
    step(1);
    chk("t1_c22_done", done, 1'b0);
    chk("t1_c22_speed", speed, 4'd15);

    // Slide from 1 up to the ceiling
    mem[0] = mk(0, 0, 8, 1);
    ticks_per_row = 4'd15; pat_len = 6'd0;
    start_play();
    step(2);
    chk("slide_c3", speed, 4'd1);
    for (int k = 1; k <= 14; k++) begin
      step(4);
      chk("slide_tick", speed, 32'(1 + k));
    end
    step(3);
    chk("slide_hold", speed, 4'd15);
    chk("slide_not_done", done, 1'b0);
    step(1);
    chk("slide_done", done, 1'b1);
    chk("slide_final", speed, 4'd15);

    // Drop from 4 down to the floor
    mem[0] = mk(3, 0, 8, 3);
    ticks_per_row = 4'd4;
    start_play();
    step(2);
    chk("drop_c3", speed, 4'd4);
    for (int k = 1; k <= 3; k++) begin
      step(4);
      chk("drop_tick", speed, 32'(4 - k));
    end
    step(4);
    chk("drop_floor", speed, 4'd1);
    chk("drop_done", done, 1'b1);

    // Fade in to volume 3
    mem[0] = mk(0, 0, 3, 4);
    ticks_per_row = 4'd5;
    start_play();
    step(2);
    chk("fadein_c3", note[7:3], 5'd0);
    for (int k = 1; k <= 3; k++) begin
      step(4);
      chk("fadein_tick", note[7:3], 32'(k));
    end
    step(4);
    chk("fadein_sat", note[7:3], 5'd3);
    step(4);
    chk("fadein_done", done, 1'b1);

    // Fade out from volume 2
    mem[0] = mk(0, 0, 2, 5);
    ticks_per_row = 4'd4;
    start_play();
    step(2);
    chk("fadeout_c3", note[7:3], 5'd2);
    step(4);
    chk("fadeout_c7", note[7:3], 5'd1);
    step(4);
    chk("fadeout_c11", note[7:3], 5'd0);
    step(4);
    chk("fadeout_c15", note[7:3], 5'd0);
    step(4);
    chk("fadeout_done", done, 1'b1);

    // Rest row between two notes; held slide keeps going
    mem[0] = mk(0, 0, 10, 1);
    mem[1] = 16'h0000;
    mem[2] = mk(5, 1, 8, 0);
    ticks_per_row = 4'd2; pat_len = 6'd2;
    start_play();
    step(2);
    chk("rest_c3_speed", speed, 4'd1);
    step(8);
    chk("rest_c11_speed", speed, 4'd3);
    step(2);
    chk("rest_c13_strobe", row_strobe, 1'b1);
    chk("rest_c13_note", note, mk(0, 0, 10, 1));
    chk("rest_c13_speed", speed, 4'd3);
    step(4);
    chk("rest_c17_speed", speed, 4'd4);
    step(6);
    chk("rest_c23_strobe", row_strobe, 1'b1);
    chk("rest_c23_note", note, mk(5, 1, 8, 0));
    chk("rest_c23_speed", speed, 4'd6);
    step(8);
    chk("rest_done", done, 1'b1);

    // Loop a single row, then stop
    mem[0] = mk(1, 1, 20, 0);
    ticks_per_row = 4'd3; pat_len = 6'd0; loop = 1'b1;
    start_play();
    step(2);
    chk("loop_c3_strobe", row_strobe, 1'b1);
    chk("loop_c3_speed", speed, 4'd2);
    step(13);
    chk("loop_c16_strobe", row_strobe, 1'b0);
    step(1);
    chk("loop_c17_strobe", row_strobe, 1'b1);
    chk("loop_c17_addr", mem_addr, 6'd0);
    done_hits = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (done) done_hits++;
    end
    chk("loop_c31_strobe", row_strobe, 1'b1);
    chk("loop_c31_addr", mem_addr, 6'd0);
    chk("loop_no_done", done_hits, 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_playing", playing, 1'b0);
    chk("stop_no_done", done, 1'b0);
    chk("stop_vol", note[7:3], 5'd0);
    loop = 1'b0;

    // ticks_per_row of 0 plays one tick per row
    mem[0] = mk(0, 0, 8, 1);
    ticks_per_row = 4'd0;
    start_play();
    step(2);
    chk("tpr0_c3_speed", speed, 4'd1);
    step(3);
    chk("tpr0_c6_done", done, 1'b0);
    step(1);
    chk("tpr0_c7_done", done, 1'b1);
    chk("tpr0_c7_speed", speed, 4'd2);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_playing", playing, 1'b0);
    chk("startstop_mem_rd", mem_rd, 1'b0);
    step(1);
    chk("startstop_playing2", playing, 1'b0);

    // Asynchronous reset mid-row
    mem[0] = mk(2, 2, 31, 0);
    ticks_per_row = 4'd2;
    start_play();
    step(4);
    chk("prerst_playing", playing, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_note", note, 16'h0000);
    chk("midrst_speed", speed, 4'd0);
    chk("midrst_playing", playing, 1'b0);
    chk("midrst_mem_rd", mem_rd, 1'b0);
    chk("midrst_strobe", row_strobe, 1'b0);
    step(1);
    rst = 1'b0;
    step(3);
    chk("postrst_mem_rd", mem_rd, 1'b0);
    chk("postrst_playing", playing, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
